vga_scan_driver: RTL and testbench

Display-side end of the scan-address/pixel interface used by the game logic.
- Generates 640x480@60 Hz scan timing and presents haddress/vaddress to the pixel producer.
- Accepts the producer's pixel value a fixed PIX_LAT cycles later.
- Emits hsync/vsync/RGB, all pipeline-aligned to the same scan position.
- Replaces ad-hoc sync wiring at the top level. Runs on the 25 MHz divided clock.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/sync_delay.sv | 33 +++
 rtl/vga_scan_driver.sv | 117 +++++++++++
 tb/tb_vga_scan_driver.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync/blank bundle carried
// through the output pipeline of vga_scan_driver.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bits_t;

    localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

    // Inclusive window test on an unsigned scan count, no subtraction involved.
    function automatic logic in_window(logic [9:0] x, logic [9:0] lo, logic [9:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with synchronous reset of every stage to RESET_VAL.
module sync_delay #(
    parameter int                WIDTH     = 3,
    parameter int                DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) stage_reg[gi] <= RESET_VAL;
                    else       stage_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) stage_reg[gi] <= RESET_VAL;
                    else       stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// Scan counter plus output pipeline: presents addresses to the pixel producer and
// emits sync/blank/RGB aligned to the pixel returned PIX_LAT cycles later.
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIX_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  pixel_in,
    output logic [9:0]  haddress,
    output logic [9:0]  vaddress,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_reg, v_reg;
    logic [9:0] h_next, v_next;
    logic       h_wrap;

    always_comb begin
        h_wrap = (h_reg == H_LAST);
        h_next = h_wrap ? 10'd0 : h_reg + 10'd1;
        v_next = v_reg;
        if (h_wrap) v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_reg <= 10'd0;
            v_reg <= 10'd0;
        end else begin
            h_reg <= h_next;
            v_reg <= v_next;
        end
    end

    assign haddress = h_reg;
    assign vaddress = v_reg;

    // Decoded straight from the address so it coincides with (0,0), including the
    // first cycle after reset; held low while reset is asserted.
    assign frame_start = ~reset && (h_reg == 10'd0) && (v_reg == 10'd0);

    logic       active_raw;
    sync_bits_t sync_raw, sync_dly;
    logic       active_dly;

    always_comb begin
        active_raw     = (h_reg < H_ACT) && (v_reg < V_ACT);
        sync_raw.hs    = ~in_window(h_reg, HS_START, HS_END);
        sync_raw.vs    = ~in_window(v_reg, VS_START, VS_END);
        sync_raw.blank = ~active_raw;
    end

    // Sync/blank travel one stage further than the active flag: the extra stage
    // matches the register that captures pixel_in.
    sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIX_LAT + 1),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .d     (sync_raw),
        .q     (sync_dly)
    );

    sync_delay #(
        .WIDTH     (1),
        .DEPTH     (PIX_LAT),
        .RESET_VAL (1'b0)
    ) u_active_delay (
        .clk   (clk),
        .reset (reset),
        .d     (active_raw),
        .q     (active_dly)
    );

    logic [3:0] rgb_reg;

    always_ff @(posedge clk) begin
        if (reset)           rgb_reg <= 4'd0;
        else if (active_dly) rgb_reg <= pixel_in;
        else                 rgb_reg <= 4'd0;
    end

    assign hsync = sync_dly.hs;
    assign vsync = sync_dly.vs;
    assign blank = sync_dly.blank;
    assign red   = rgb_reg;
    assign green = rgb_reg;
    assign blue  = rgb_reg;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Two instances: full 640x480 timing with PIX_LAT=1 and a shrunken raster with
// PIX_LAT=3 so whole frames fit; both checked against an arithmetic scan model.
`timescale 1ns/1ps
module tb_vga_scan_driver;

    localparam int HA  [2] = '{640, 16};
    localparam int HFP [2] = '{16, 2};
    localparam int HSY [2] = '{96, 4};
    localparam int HBP [2] = '{48, 3};
    localparam int VA  [2] = '{480, 8};
    localparam int VFP [2] = '{10, 2};
    localparam int VSY [2] = '{2, 2};
    localparam int VBP [2] = '{33, 3};
    localparam int LAT [2] = '{1, 3};

    logic       clk = 1'b0;
    logic       rst [2];
    logic [3:0] pix [2];
    logic [9:0] haddr [2];
    logic [9:0] vaddr [2];
    logic       fs [2];
    logic       hs [2];
    logic       vs [2];
    logic       bl [2];
    logic [3:0] r [2];
    logic [3:0] g [2];
    logic [3:0] b [2];

    int checks = 0;
    int failures = 0;
    int pix_mode = 0;
    int n [2];
    logic [3:0] hist [2][4096];

    always #20 clk = ~clk;

    vga_scan_driver #(.PIX_LAT(1)) dut_a (
        .clk(clk), .reset(rst[0]), .pixel_in(pix[0]),
        .haddress(haddr[0]), .vaddress(vaddr[0]), .frame_start(fs[0]),
        .hsync(hs[0]), .vsync(vs[0]), .blank(bl[0]),
        .red(r[0]), .green(g[0]), .blue(b[0])
    );

    vga_scan_driver #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(3)
    ) dut_b (
        .clk(clk), .reset(rst[1]), .pixel_in(pix[1]),
        .haddress(haddr[1]), .vaddress(vaddr[1]), .frame_start(fs[1]),
        .hsync(hs[1]), .vsync(vs[1]), .blank(bl[1]),
        .red(r[1]), .green(g[1]), .blue(b[1])
    );

    // Cycles elapsed since reset was last sampled high.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) n[d] <= rst[d] ? 0 : n[d] + 1;
    end

    function automatic int htot(int d);
        return HA[d] + HFP[d] + HSY[d] + HBP[d];
    endfunction
    function automatic int vtot(int d);
        return VA[d] + VFP[d] + VSY[d] + VBP[d];
    endfunction
    function automatic int hof(int d, int t);
        return t % htot(d);
    endfunction
    function automatic int vof(int d, int t);
        return (t / htot(d)) % vtot(d);
    endfunction
    function automatic logic act(int d, int t);
        return hof(d, t) < HA[d] && vof(d, t) < VA[d];
    endfunction
    function automatic logic hs_exp(int d, int t);
        return !(hof(d, t) >= HA[d] + HFP[d] && hof(d, t) < HA[d] + HFP[d] + HSY[d]);
    endfunction
    function automatic logic vs_exp(int d, int t);
        return !(vof(d, t) >= VA[d] + VFP[d] && vof(d, t) < VA[d] + VFP[d] + VSY[d]);
    endfunction

    // Pixel producer: invents a value per address, returns it LAT cycles later.
    initial begin
        pix[0] = 4'd0;
        pix[1] = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                int t;
                t = n[d];
                case (pix_mode)
                    1:       hist[d][t % 4096] = 4'(hof(d, t));
                    2:       hist[d][t % 4096] = 4'hF;
                    default: hist[d][t % 4096] = 4'($urandom);
                endcase
                pix[d] = (t >= LAT[d]) ? hist[d][(t - LAT[d]) % 4096] : 4'($urandom);
            end
        end
    end

    task automatic test_reset;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({haddr[d], vaddr[d]} !== 20'd0) begin
                failures++;
                $display("FAIL reset_addr dut%0d got h=%0d v=%0d want 0,0", d, haddr[d], vaddr[d]);
            end
            checks++;
            if ({fs[d], hs[d], vs[d], bl[d]} !== 4'b0111) begin
                failures++;
                $display("FAIL reset_ctl dut%0d got fs/hs/vs/bl=%b%b%b%b want 0111", d, fs[d], hs[d], vs[d], bl[d]);
            end
            checks++;
            if ({r[d], g[d], b[d]} !== 12'd0) begin
                failures++;
                $display("FAIL reset_rgb dut%0d got %h%h%h want 000", d, r[d], g[d], b[d]);
            end
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (fs[d] !== 1'b1 || haddr[d] !== 10'd0) begin
                failures++;
                $display("FAIL release_frame_start dut%0d got fs=%b h=%0d want fs=1 h=0", d, fs[d], haddr[d]);
            end
        end
    endtask

    task automatic test_hsync_timing;
        int fall1 = -1, rise1 = -1, fall2 = -1;
        logic prev, cur;
        prev = hs[0];
        repeat (1700) begin
            @(negedge clk);
            cur = hs[0];
            if (prev && !cur) begin
                if (fall1 < 0) fall1 = n[0];
                else if (fall2 < 0) fall2 = n[0];
            end
            if (!prev && cur && fall1 >= 0 && rise1 < 0) rise1 = n[0];
            prev = cur;
        end
        checks++;
        if (fall1 != HA[0] + HFP[0] + LAT[0] + 1) begin
            failures++;
            $display("FAIL hsync_first_low got %0d want %0d", fall1, HA[0] + HFP[0] + LAT[0] + 1);
        end
        checks++;
        if (rise1 - fall1 != HSY[0]) begin
            failures++;
            $display("FAIL hsync_width got %0d want %0d", rise1 - fall1, HSY[0]);
        end
        checks++;
        if (fall2 - fall1 != htot(0)) begin
            failures++;
            $display("FAIL hsync_period got %0d want %0d", fall2 - fall1, htot(0));
        end
    endtask

    task automatic test_vsync_frame;
        int fall = -1, rise = -1, fs1 = -1, fs2 = -1, max_v = 0;
        int ft;
        logic prev, cur;
        ft = htot(1) * vtot(1);
        prev = vs[1];
        repeat (3 * 375 + 60) begin
            @(negedge clk);
            cur = vs[1];
            if (prev && !cur && fall < 0) fall = n[1];
            if (!prev && cur && fall >= 0 && rise < 0) rise = n[1];
            if (fs[1] === 1'b1) begin
                if (fs1 < 0) fs1 = n[1];
                else if (fs2 < 0) fs2 = n[1] + (n[1] < fs1 ? 1 << 30 : 0);
            end
            if (int'(vaddr[1]) > max_v) max_v = int'(vaddr[1]);
            prev = cur;
        end
        checks++;
        if (rise - fall != VSY[1] * htot(1)) begin
            failures++;
            $display("FAIL vsync_width got %0d want %0d", rise - fall, VSY[1] * htot(1));
        end
        checks++;
        if (fall % ft != (VA[1] + VFP[1]) * htot(1) + LAT[1] + 1) begin
            failures++;
            $display("FAIL vsync_position got %0d want %0d", fall % ft, (VA[1] + VFP[1]) * htot(1) + LAT[1] + 1);
        end
        checks++;
        if (fs2 - fs1 != ft) begin
            failures++;
            $display("FAIL frame_start_period got %0d want %0d", fs2 - fs1, ft);
        end
        checks++;
        if (max_v != vtot(1) - 1) begin
            failures++;
            $display("FAIL vaddress_max got %0d want %0d", max_v, vtot(1) - 1);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the scan model.
    task automatic test_scan(int cycles, int mode);
        pix_mode = mode;
        repeat (cycles) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int t, u;
                logic e_hs, e_vs, e_bl;
                logic [3:0] e_rgb;
                t = n[d];
                u = t - LAT[d] - 1;
                e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_rgb = 4'd0;
                if (u >= 0) begin
                    e_hs = hs_exp(d, u);
                    e_vs = vs_exp(d, u);
                    e_bl = !act(d, u);
                    e_rgb = act(d, u) ? hist[d][u % 4096] : 4'd0;
                end
                checks++;
                if (haddr[d] !== 10'(hof(d, t)) || vaddr[d] !== 10'(vof(d, t))) begin
                    failures++;
                    $display("FAIL scan_addr dut%0d n=%0d got %0d,%0d want %0d,%0d", d, t, haddr[d], vaddr[d], hof(d, t), vof(d, t));
                end
                checks++;
                if (fs[d] !== (hof(d, t) == 0 && vof(d, t) == 0)) begin
                    failures++;
                    $display("FAIL scan_frame_start dut%0d n=%0d got %b", d, t, fs[d]);
                end
                checks++;
                if ({hs[d], vs[d], bl[d]} !== {e_hs, e_vs, e_bl}) begin
                    failures++;
                    $display("FAIL scan_sync dut%0d n=%0d got hs/vs/bl=%b%b%b want %b%b%b", d, t, hs[d], vs[d], bl[d], e_hs, e_vs, e_bl);
                end
                checks++;
                if ({r[d], g[d], b[d]} !== {e_rgb, e_rgb, e_rgb}) begin
                    failures++;
                    $display("FAIL scan_rgb dut%0d n=%0d got %h%h%h want %h", d, t, r[d], g[d], b[d], e_rgb);
                end
            end
        end
    endtask

    task automatic test_blanking;
        int nz = 0;
        int leak [2] = '{0, 0};
        pix_mode = 2;
        repeat (8) @(negedge clk);
        repeat (375) begin
            @(negedge clk);
            if (r[1] !== 4'd0) nz++;
            for (int d = 0; d < 2; d++)
                if (bl[d] !== 1'b0 && {r[d], g[d], b[d]} !== 12'd0) leak[d]++;
        end
        checks++;
        if (nz != HA[1] * VA[1]) begin
            failures++;
            $display("FAIL blank_nonzero_count got %0d want %0d", nz, HA[1] * VA[1]);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (leak[d] != 0) begin
                failures++;
                $display("FAIL blank_leak dut%0d got %0d want 0", d, leak[d]);
            end
        end
    endtask

    task automatic test_mid_frame_reset(int d, int ht, int vt);
        bit found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(posedge clk);
            #2;
            if (hof(d, n[d]) == ht && (vt < 0 || vof(d, n[d]) == vt)) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midreset_wait dut%0d got timeout want h=%0d", d, ht);
            return;
        end
        rst[d] = 1'b1;
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        @(negedge clk);
        checks++;
        if ({haddr[d], vaddr[d]} !== 20'd0 || {r[d], g[d], b[d]} !== 12'd0) begin
            failures++;
            $display("FAIL midreset_state dut%0d got h=%0d v=%0d rgb=%h want 0,0,0", d, haddr[d], vaddr[d], r[d]);
        end
        checks++;
        if ({fs[d], hs[d], vs[d], bl[d]} !== 4'b1111) begin
            failures++;
            $display("FAIL midreset_ctl dut%0d got fs/hs/vs/bl=%b%b%b%b want 1111", d, fs[d], hs[d], vs[d], bl[d]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_hsync_timing;
        test_vsync_frame;
        test_scan(3000, 0);
        test_scan(1000, 1);
        test_blanking;
        test_mid_frame_reset(0, 300, -1);
        test_scan(1000, 0);
        test_mid_frame_reset(1, 10, 5);
        test_scan(800, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
